// File: rtl/fir_mac_engine.sv
// Time-multiplexed FIR multiply-accumulate engine: pops {a,b} operand words from a
// sync FIFO, accumulates TAPS products per output, then scales, saturates and hands off.
module fir_mac_engine #(
    parameter int TAPS  = 35,
    parameter int SHIFT = 18,
    parameter int OUT_W = 17
) (
    input  logic             MACCLK,
    input  logic             RST,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [42:0]      fifo_dout,
    input  logic             clr,
    output logic [OUT_W-1:0] y_out,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             y_sat
);

    localparam int CW = $clog2(TAPS);
    localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);
    localparam logic signed [47:0] MAX_V = (48'sd1 <<< (OUT_W - 1)) - 48'sd1;
    localparam logic signed [47:0] MIN_V = -(48'sd1 <<< (OUT_W - 1));

    logic [CW-1:0]       rcnt;
    logic                last_tap;
    logic                blocked;

    logic                rd_v, rd_first, rd_last;
    logic                s1_v, s1_first, s1_last;
    logic signed [17:0]  s1_a;
    logic signed [24:0]  s1_b;
    logic                s2_v, s2_first, s2_last;
    logic signed [47:0]  s2_p;

    logic signed [47:0]  acc;
    logic signed [47:0]  acc_next;
    logic signed [47:0]  shifted;
    logic [OUT_W-1:0]    sat_val;
    logic                sat_flag;

    assign last_tap = (rcnt == LAST_TAP);

    // The last tap may only be read once the previous result can be replaced,
    // otherwise a held output would be overwritten.
    assign blocked    = last_tap && y_valid && !y_ready;
    assign fifo_rd_en = !fifo_empty && !clr && !RST && !blocked;

    always_ff @(posedge MACCLK or posedge RST) begin
        if (RST) begin
            rcnt     <= '0;
            rd_v     <= 1'b0;
            rd_first <= 1'b0;
            rd_last  <= 1'b0;
        end else if (clr) begin
            rcnt     <= '0;
            rd_v     <= 1'b0;
            rd_first <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            rd_v     <= fifo_rd_en;
            rd_first <= (rcnt == '0);
            rd_last  <= last_tap;
            if (fifo_rd_en)
                rcnt <= last_tap ? '0 : rcnt + CW'(1);
        end
    end

    // Operand capture: the FIFO presents data the cycle after the strobe.
    always_ff @(posedge MACCLK or posedge RST) begin
        if (RST) begin
            s1_v     <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_v     <= clr ? 1'b0 : rd_v;
            s1_first <= rd_first;
            s1_last  <= rd_last;
            s1_a     <= fifo_dout[42:25];
            s1_b     <= fifo_dout[24:0];
        end
    end

    always_ff @(posedge MACCLK or posedge RST) begin
        if (RST) begin
            s2_v     <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_p     <= '0;
        end else begin
            s2_v     <= clr ? 1'b0 : s1_v;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_p     <= s1_a * s1_b;
        end
    end

    always_comb begin
        acc_next = s2_first ? s2_p : acc + s2_p;
        shifted  = acc_next >>> SHIFT;
        sat_flag = 1'b0;
        sat_val  = shifted[OUT_W-1:0];
        if (shifted > MAX_V) begin
            sat_val  = MAX_V[OUT_W-1:0];
            sat_flag = 1'b1;
        end else if (shifted < MIN_V) begin
            sat_val  = MIN_V[OUT_W-1:0];
            sat_flag = 1'b1;
        end
    end

    // Accumulate and publish; clr wins over a result landing on the same edge.
    always_ff @(posedge MACCLK or posedge RST) begin
        if (RST) begin
            acc     <= '0;
            y_out   <= '0;
            y_valid <= 1'b0;
            y_sat   <= 1'b0;
        end else if (clr) begin
            acc     <= '0;
            y_valid <= 1'b0;
        end else begin
            if (s2_v)
                acc <= acc_next;
            if (s2_v && s2_last) begin
                y_out   <= sat_val;
                y_sat   <= sat_flag;
                y_valid <= 1'b1;
            end else if (y_valid && y_ready) begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule
